// File: rtl/lcd_controller_if.sv
// CPU-side bus of the character-LCD controller.
// On every rising edge where chip_en & read_write are both high the controller
// takes a write. There is no ready or backpressure: a byte pushed into a full
// FIFO is dropped and flagged as overflow. Reads are combinational from
// data_out while chip_en is high and read_write is low.
interface lcd_controller_if;
    logic       chip_en;
    logic       read_write;
    logic [1:0] register_select;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output chip_en,
        output read_write,
        output register_select,
        output data_in,
        input  data_out
    );

    modport slave (
        input  chip_en,
        input  read_write,
        input  register_select,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/lcd_controller.sv
// HD44780 character-LCD driver. The CPU queues {rs,byte} entries in a small
// FIFO; the sequencer replays each one on the panel pins with setup, enable
// pulse, hold and execution delays, so the panel busy flag is never read.
module lcd_controller #(
    parameter int FIFO_DEPTH       = 4,
    parameter int POWERUP_CYCLES   = 750000,
    parameter int SETUP_CYCLES     = 2,
    parameter int EN_CYCLES        = 25,
    parameter int HOLD_CYCLES      = 2,
    parameter int EXEC_CYCLES      = 2000,
    parameter int LONG_EXEC_CYCLES = 82000
) (
    input  logic              clk,
    input  logic              reset,
    lcd_controller_if.slave   bus,
    output logic [7:0]        lcd_data,
    output logic              lcd_en,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_on,
    output logic              lcd_blon,
    output logic [2:0]        state_dbg
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    localparam int M1 = (POWERUP_CYCLES > LONG_EXEC_CYCLES) ? POWERUP_CYCLES : LONG_EXEC_CYCLES;
    localparam int M2 = (M1 > EXEC_CYCLES) ? M1 : EXEC_CYCLES;
    localparam int M3 = (M2 > EN_CYCLES) ? M2 : EN_CYCLES;
    localparam int M4 = (M3 > SETUP_CYCLES) ? M3 : SETUP_CYCLES;
    localparam int MAX_CYC = (M4 > HOLD_CYCLES) ? M4 : HOLD_CYCLES;
    localparam int CW = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_PULSE   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_EXEC    = 3'd5
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            init_done;

    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] fifo_count;
    logic            overflow;

    logic            wr_strobe;
    logic            push_req;
    logic            ctrl_wr;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    logic [8:0]      head;
    logic            is_long;
    logic            busy;
    logic [2:0]      cnt_disp;

    assign wr_strobe = bus.chip_en & bus.read_write;
    assign push_req  = wr_strobe & ~bus.register_select[1];
    assign ctrl_wr   = wr_strobe & (bus.register_select == 2'd3);
    assign fifo_full = (fifo_count == CNTW'(FIFO_DEPTH));
    assign pop       = (state == ST_IDLE) && (fifo_count != '0);
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_ok   = push_req & (~fifo_full | pop);
    assign head      = mem[rd_ptr];

    // Clear and return-home commands need the long execution wait.
    assign is_long   = ~lcd_rs & ((lcd_data == 8'h01) | (lcd_data == 8'h02) | (lcd_data == 8'h03));
    assign busy      = (state != ST_IDLE) | (fifo_count != '0);
    assign lcd_rw    = 1'b0;
    assign state_dbg = state;

    // FIFO occupancy shown to software saturates at 7.
    always_comb begin
        cnt_disp = (int'(fifo_count) > 7) ? 3'd7 : 3'(fifo_count);
    end

    // CPU read mux; reads never change any state.
    always_comb begin
        bus.data_out = 8'h00;
        if (bus.chip_en && !bus.read_write) begin
            case (bus.register_select)
                2'd2:    bus.data_out = {busy, overflow, init_done, 2'b00, cnt_disp};
                2'd3:    bus.data_out = {6'b0, lcd_blon, lcd_on};
                default: bus.data_out = 8'h00;
            endcase
        end
    end

    // FIFO storage; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {bus.register_select[0], bus.data_in};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNTW'(1);
                2'b01:   fifo_count <= fifo_count - CNTW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && bus.data_in[7]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Panel power and backlight control register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_on   <= 1'b0;
            lcd_blon <= 1'b0;
        end else if (ctrl_wr) begin
            lcd_on   <= bus.data_in[0];
            lcd_blon <= bus.data_in[1];
        end
    end

    // Transfer sequencer: power-up wait, then setup / pulse / hold / exec per byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_POWERUP;
            cnt       <= '0;
            init_done <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            case (state)
                ST_POWERUP: begin
                    if (cnt == CW'(POWERUP_CYCLES - 1)) begin
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    if (fifo_count != '0) begin
                        lcd_rs   <= head[8];
                        lcd_data <= head[7:0];
                        state    <= ST_SETUP;
                        cnt      <= '0;
                    end
                end
                ST_SETUP: begin
                    if (cnt == CW'(SETUP_CYCLES - 1)) begin
                        lcd_en <= 1'b1;
                        state  <= ST_PULSE;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt == CW'(EN_CYCLES - 1)) begin
                        lcd_en <= 1'b0;
                        state  <= ST_HOLD;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        state <= ST_EXEC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_EXEC: begin
                    if (cnt == (is_long ? CW'(LONG_EXEC_CYCLES - 1) : CW'(EXEC_CYCLES - 1))) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    lcd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_controller.sv
// Bench for lcd_controller with short simulation timing parameters.
module tb_lcd_controller;
    localparam int P_PWR = 20;
    localparam int P_S   = 2;
    localparam int P_E   = 3;
    localparam int P_H   = 2;
    localparam int P_X   = 10;
    localparam int P_L   = 40;
    localparam int P_D   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] lcd_data;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_on;
    logic       lcd_blon;
    logic [2:0] state_dbg;

    lcd_controller_if bus ();

    lcd_controller #(
        .FIFO_DEPTH      (P_D),
        .POWERUP_CYCLES  (P_PWR),
        .SETUP_CYCLES    (P_S),
        .EN_CYCLES       (P_E),
        .HOLD_CYCLES     (P_H),
        .EXEC_CYCLES     (P_X),
        .LONG_EXEC_CYCLES(P_L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .lcd_data (lcd_data),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_on   (lcd_on),
        .lcd_blon (lcd_blon),
        .state_dbg(state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected panel transfers: {chained, rs, data}; chained means the byte
    // was already queued when the previous one started, so it follows back-to-back.
    logic [9:0] exp_q[$];
    bit         mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
            $error("check %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Full time from pop to the next pop for one byte.
    function automatic int byte_period(input logic rs, input logic [7:0] d);
        int x;
        x = (!rs && d >= 8'd1 && d <= 8'd3) ? P_L : P_X;
        return 1 + P_S + P_E + P_H + x;
    endfunction

    // Driver tasks; called at a falling edge, return at a falling edge.
    task automatic bus_write(input logic [1:0] rs, input logic [7:0] d);
        bus.chip_en         = 1'b1;
        bus.read_write      = 1'b1;
        bus.register_select = rs;
        bus.data_in         = d;
        @(negedge clk);
        bus.chip_en    = 1'b0;
        bus.read_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] rs, output logic [7:0] v);
        bus.chip_en         = 1'b1;
        bus.read_write      = 1'b0;
        bus.register_select = rs;
        #1;
        v = bus.data_out;
        bus.chip_en = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int n);
        logic [7:0] v;
        n = 0;
        bus_read(2'd2, v);
        while (v[7] && n < limit) begin
            @(negedge clk);
            n++;
            bus_read(2'd2, v);
        end
    endtask

    // Panel monitor: every enable pulse must carry the next expected byte,
    // last exactly EN cycles, keep rs/data steady, and chained bytes must
    // start one full byte period after their predecessor.
    logic [9:0] cur;
    logic [8:0] prev_byte;
    int         last_rise;
    int         hi_cnt;
    bit         have_prev = 1'b0;
    bit         in_pulse  = 1'b0;
    logic       prev_en   = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (lcd_en && !prev_en) begin
                chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                chk("lcd_rw_zero", 32'(lcd_rw), 32'd0);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("pulse_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, cur[8:0]});
                    if (cur[9] && have_prev) begin
                        chk("rise_gap", 32'(cyc - last_rise), 32'(byte_period(prev_byte[8], prev_byte[7:0])));
                    end
                    prev_byte = cur[8:0];
                    last_rise = cyc;
                    have_prev = 1'b1;
                    in_pulse  = 1'b1;
                end
                hi_cnt = 1;
            end else if (lcd_en) begin
                hi_cnt++;
            end
            if (!lcd_en && prev_en && in_pulse) begin
                chk("pulse_width", 32'(hi_cnt), 32'(P_E));
                chk("hold_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, prev_byte});
                in_pulse = 1'b0;
            end
        end else begin
            in_pulse  = 1'b0;
            have_prev = 1'b0;
        end
        prev_en = lcd_en;
    end

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed and randomized stimulus.
    initial begin
        logic [7:0] v;
        logic       rs;
        logic [7:0] d;
        int         n;
        int         nb;
        bit         en_seen;

        reset               = 1'b1;
        bus.chip_en         = 1'b0;
        bus.read_write      = 1'b0;
        bus.register_select = 2'd0;
        bus.data_in         = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_lcd_en", 32'(lcd_en), 32'd0);
        chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        chk("rst_lcd_data", 32'(lcd_data), 32'd0);
        chk("rst_lcd_rw", 32'(lcd_rw), 32'd0);
        chk("rst_lcd_on", {30'd0, lcd_blon, lcd_on}, 32'd0);
        bus_read(2'd2, v);
        chk("rst_status", 32'(v), 32'h80);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Command 0x38 written on the 5th edge of power-up.
        repeat (4) @(negedge clk);
        exp_q.push_back({1'b0, 1'b0, 8'h38});
        bus_write(2'd0, 8'h38);
        bus_read(2'd2, v);
        chk("powerup_status", 32'(v), 32'h81);
        en_seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (lcd_en) en_seen = 1'b1;
        end
        chk("no_en_before_init", 32'(en_seen), 32'd0);
        bus_read(2'd2, v);
        chk("status_edge19", 32'(v), 32'h81);
        @(negedge clk);
        bus_read(2'd2, v);
        chk("status_init_done", 32'(v), 32'hA1);
        wait_idle(500, n);
        chk("cmd_busy_cycles", 32'(n), 32'(byte_period(1'b0, 8'h38)));
        bus_read(2'd2, v);
        chk("status_idle", 32'(v), 32'h20);

        // Two data bytes back-to-back.
        exp_q.push_back({1'b0, 1'b1, 8'h41});
        exp_q.push_back({1'b1, 1'b1, 8'h42});
        bus_write(2'd1, 8'h41);
        bus_write(2'd1, 8'h42);
        wait_idle(500, n);
        chk("data_pair_timeout", 32'(n < 500), 32'd1);

        // Clear command followed by data: long execution gap.
        exp_q.push_back({1'b0, 1'b0, 8'h01});
        exp_q.push_back({1'b1, 1'b1, 8'h48});
        bus_write(2'd0, 8'h01);
        bus_write(2'd1, 8'h48);
        wait_idle(500, n);
        chk("clear_timeout", 32'(n < 500), 32'd1);

        // Control register and read decode.
        bus_write(2'd3, 8'h03);
        chk("ctrl_lcd_on", 32'(lcd_on), 32'd1);
        chk("ctrl_lcd_blon", 32'(lcd_blon), 32'd1);
        bus_read(2'd3, v);
        chk("ctrl_read", 32'(v), 32'h03);
        bus.chip_en         = 1'b0;
        bus.read_write      = 1'b0;
        bus.register_select = 2'd2;
        #1;
        chk("read_no_select", 32'(bus.data_out), 32'h00);
        bus_write(2'd2, 8'hFF);
        bus_read(2'd2, v);
        chk("status_write_ignored", 32'(v), 32'h20);

        // Random bursts of up to FIFO_DEPTH bytes written while idle.
        for (int b = 0; b < 8; b++) begin
            nb = $urandom_range(1, P_D);
            for (int i = 0; i < nb; i++) begin
                rs = 1'($urandom_range(0, 1));
                d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
                exp_q.push_back({(i != 0), rs, d});
                bus_write({1'b0, rs}, d);
            end
            wait_idle(1000, n);
            chk("burst_timeout", 32'(n < 1000), 32'd1);
            bus_read(2'd2, v);
            chk("burst_status", 32'(v), 32'h20);
        end

        // Reset in the middle of an enable pulse.
        exp_q.push_back({1'b0, 1'b1, 8'h5A});
        bus_write(2'd1, 8'h5A);
        n = 0;
        while (!lcd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_reached", 32'(n < 50), 32'd1);
        @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_lcd_en", 32'(lcd_en), 32'd0);
        chk("abort_lcd_byte", {23'd0, lcd_rs, lcd_data}, 32'd0);
        chk("abort_ctrl", {30'd0, lcd_blon, lcd_on}, 32'd0);
        bus_read(2'd2, v);
        chk("abort_status", 32'(v), 32'h80);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Six pushes during power-up: only the first four fit.
        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            if (i < P_D) exp_q.push_back({(i != 0), rs, d});
            bus_write({1'b0, rs}, d);
        end
        bus_read(2'd2, v);
        chk("overflow_status", 32'(v), 32'hC4);
        bus_write(2'd3, 8'h80);
        bus_read(2'd2, v);
        chk("overflow_cleared", 32'(v), 32'h84);
        chk("ctrl_bit7_only", {30'd0, lcd_blon, lcd_on}, 32'd0);
        en_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (lcd_en) en_seen = 1'b1;
        end
        chk("no_en_rerun_powerup", 32'(en_seen), 32'd0);
        wait_idle(1000, n);
        chk("drain_timeout", 32'(n < 1000), 32'd1);
        bus_read(2'd2, v);
        chk("final_status", 32'(v), 32'h20);
        repeat (2) @(negedge clk);
        chk("all_bytes_seen", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
